// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared constants and types for the acc_drain result drain.
//   FP16 field widths and limits, plus the drain FSM state encoding.
package acc_drain_pkg;

  localparam int          FP16_BIAS       = 15;
  localparam int          FP16_EXP_W      = 5;
  localparam int          FP16_MAN_W      = 10;
  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/acc_drain_fp16_pack.sv
// fp16_pack: combinational signed fixed-point accumulator -> IEEE FP16.
//   Value converted: acc * 2^(acc_exp - 15 - FRAC_BITS).
//   Ports:
//     acc      in  ACC_WIDTH  signed two's-complement accumulator
//     acc_exp  in  5          PE exponent (biased like FP16)
//     fp       out 16         FP16 result (saturated to max finite, flushed to signed zero)
//   Build option: ACC_DRAIN_RNE_EN selects round-to-nearest-even; otherwise the
//   magnitude is truncated and no rounding adder exists.
module fp16_pack
  import acc_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 10
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [FP16_EXP_W-1:0]       acc_exp,
  output logic [15:0]                 fp
);

  localparam int MW = ACC_WIDTH + 1;

  logic                  sign;
  logic signed [MW-1:0]  ext;
  logic [MW-1:0]         mag;
  logic [7:0]            lead;
  logic [MW-1:0]         norm;
  logic [FP16_MAN_W-1:0] man;
  logic signed [9:0]     e_pre;
  logic signed [9:0]     e_rnd;
  logic [FP16_MAN_W:0]   man_rnd;

  // Rounding of the 10-bit mantissa; bit 10 of the result is the carry-out.
`ifdef ACC_DRAIN_RNE_EN
  logic guard, sticky;

  function automatic logic [FP16_MAN_W:0] round_man(input logic [FP16_MAN_W-1:0] m,
                                                   input logic g, input logic s);
    return {1'b0, m} + (FP16_MAN_W+1)'(g & (s | m[0]));
  endfunction
`else
  logic unused_low_bits;

  function automatic logic [FP16_MAN_W:0] round_man(input logic [FP16_MAN_W-1:0] m);
    return {1'b0, m};
  endfunction
`endif

  // Final packing with overflow saturation; zero/underflow are handled earlier.
  function automatic logic [15:0] sat_pack(input logic s, input logic signed [9:0] e,
                                           input logic [FP16_MAN_W-1:0] m);
    if (e >= 10'sd31) return {s, 15'b0} | FP16_MAX_FINITE;
    return {s, e[FP16_EXP_W-1:0], m};
  endfunction

  assign sign = acc[ACC_WIDTH-1];
  assign ext  = {sign, acc};
  // One extra bit keeps |most-negative| representable.
  assign mag  = sign ? MW'(-ext) : MW'(ext);

  always_comb begin
    lead = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead = 8'(i);
    end
  end

  // Normalise so the leading one sits at the top bit of norm.
  assign norm  = mag << (8'(MW - 1) - lead);
  assign man   = norm[MW-2 -: FP16_MAN_W];
  assign e_pre = $signed({5'b0, acc_exp}) + $signed({2'b0, lead}) - 10'(FRAC_BITS);

`ifdef ACC_DRAIN_RNE_EN
  assign guard   = norm[MW-2-FP16_MAN_W];
  assign sticky  = |norm[MW-3-FP16_MAN_W:0];
  assign man_rnd = round_man(man, guard, sticky);
`else
  assign unused_low_bits = ^{norm[MW-1], norm[MW-2-FP16_MAN_W:0]};
  assign man_rnd = round_man(man);
`endif

  // Mantissa carry-out bumps the exponent (mantissa wraps to zero).
  assign e_rnd = man_rnd[FP16_MAN_W] ? e_pre + 10'sd1 : e_pre;

  always_comb begin
    fp = '0;
    if (mag == '0)           fp = 16'h0000;
    else if (e_pre <= 10'sd0) fp = {sign, 15'b0};
    else                     fp = sat_pack(sign, e_rnd, man_rnd[FP16_MAN_W-1:0]);
  end

endmodule

// File: rtl/acc_drain.sv
// acc_drain: snapshots N*N PE accumulators on a rising edge of done, converts
//   each to FP16 and streams them row-major over valid/ready.
//   Ports:
//     clk, rst (async, active-low)
//     done               in   mm done level, captured on 0->1
//     acc_in / exp_in    in   flattened accumulators / exponents, PE l at l*W
//     out_valid/ready    handshake; out_data FP16, out_idx PE index, out_last final PE
//     busy               out  drain in progress
//     overrun            out  sticky: done rose while busy
//   Build option: ACC_DRAIN_RNE_EN (round-to-nearest-even in fp16_pack).
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 2,
  parameter int FRAC_BITS = 10,
  parameter int IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done,
  input  logic [N*N*ACC_WIDTH-1:0] acc_in,
  input  logic [N*N*5-1:0]       exp_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun
);

  localparam int               NN       = N * N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  state_t state, state_d;
  logic   done_q;
  logic   rise, capture, load_out, hs;
  logic [IDX_W-1:0] idx;
  logic [15:0] fp;

  logic signed [ACC_WIDTH-1:0] snap_acc [NN];
  logic [4:0]                  snap_exp [NN];

  assign rise = done & ~done_q;
  assign busy = (state != IDLE);

  fp16_pack #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_pack (
    .acc     (snap_acc[idx]),
    .acc_exp (snap_exp[idx]),
    .fp      (fp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    capture  = 1'b0;
    load_out = 1'b0;
    hs       = 1'b0;
    case (state)
      IDLE: if (rise) begin
        capture = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        load_out = 1'b1;
        state_d  = SEND;
      end
      SEND: if (out_ready) begin
        hs      = 1'b1;
        state_d = (idx == LAST_IDX) ? IDLE : CONV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q    <= 1'b0;
      overrun   <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int l = 0; l < NN; l++) begin
        snap_acc[l] <= '0;
        snap_exp[l] <= '0;
      end
    end else begin
      done_q <= done;
      // A rise that lands outside IDLE is dropped, but remembered.
      if (rise && busy) overrun <= 1'b1;
      if (capture) begin
        idx <= '0;
        for (int l = 0; l < NN; l++) begin
          snap_acc[l] <= acc_in[l*ACC_WIDTH +: ACC_WIDTH];
          snap_exp[l] <= exp_in[l*5 +: 5];
        end
      end
      if (load_out) begin
        out_data  <= fp;
        out_idx   <= idx;
        out_last  <= (idx == LAST_IDX);
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: doc/acc_drain.md
# acc_drain

Output drain stage directly downstream of the `mm` matrix-multiply wrapper. On a rising edge of `mm.done` it snapshots all N×N PE accumulators and exponents, converts each signed fixed-point accumulator into an IEEE FP16 word, and streams the results row-major over a valid/ready interface. It decouples the systolic array from the result consumer so the array can be re-armed while results drain.

## Interface
Parameters:
- `ACC_WIDTH`, 32: accumulator width, signed two's complement.
- `N`, 2: array dimension; N*N results per drain.
- `FRAC_BITS`, 10: fixed-point fraction bits of the accumulator.
- `IDX_W`, `$clog2(N*N)` (min 1): width of the result index.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `done`  in  1  `mm` done level; captured on its 0→1 transition.
- `acc_in`  in  N*N*ACC_WIDTH  flattened accumulators, PE l at bits [l*ACC_WIDTH +: ACC_WIDTH], l = row*N+col.
- `exp_in`  in  N*N*5  flattened PE exponents, PE l at [l*5 +: 5].
- `out_valid`  out  1  out_data holds a result.
- `out_ready`  in  1  consumer accepts when high with out_valid.
- `out_data`  out  16  FP16 result.
- `out_idx`  out  IDX_W  PE index l of out_data.
- `out_last`  out  1  high with the final (l = N*N-1) result.
- `busy`  out  1  drain in progress.
- `overrun`  out  1  sticky: a done rise arrived while busy.

## Operation
- Value represented by PE l: acc × 2^(exp − 15 − FRAC_BITS).
- FSM states: IDLE, CONV, SEND.
  - IDLE: `done` high and registered `done_q` low → copy all acc_in/exp_in into snapshot registers, idx←0, → CONV.
  - CONV: convert snapshot[idx], register into out_data/out_idx/out_last, out_valid←1, → SEND.
  - SEND: hold outputs stable until out_ready. On handshake: out_valid←0; if idx = N*N−1 → IDLE, else idx←idx+1, → CONV.
- Conversion: sign = acc MSB; mag = |acc| in ACC_WIDTH+1 bits (handles most negative value); p = leading-one position; biased exponent E = exp + p − FRAC_BITS; mantissa = 10 bits below the leading one.
  - acc = 0 → 16'h0000.
  - E ≥ 31 → saturate to sign | 16'h7BFF.
  - E ≤ 0 → flush to signed zero (sign<<15).
  - Rounding increments that carry out of the mantissa bump E; a bump to 31 saturates.
- busy = (state ≠ IDLE). A done rise while busy is ignored; overrun←1 until reset.
- Snapshot is independent of acc_in after capture; `mm` may restart immediately.

## Timing
- Reset: state IDLE, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0, overrun 0, done_q 0, snapshot 0.
- Capture edge E0; out_valid high after E0+1; each element occupies ≥2 cycles (CONV + SEND). With out_ready tied high, full drain = 2·N·N cycles after E0, busy falls the cycle after the last handshake.
- out_data/out_idx/out_last must not change while out_valid=1 and out_ready=0.
- done rise in the same cycle the last handshake completes: state is SEND, so ignored and flagged overrun.
- rst asserted mid-drain: immediate return to reset values; pending results discarded.

## Configuration
- `ACC_DRAIN_RNE_EN` defined: round-to-nearest-even using guard/sticky bits below the mantissa.
- Undefined: truncate toward zero (magnitude truncation); no rounding adder instantiated.

## Structure
- Package `acc_drain_pkg`: FP16_BIAS = 15, FP16_MAX_FINITE = 16'h7BFF, FP16 field widths, state enum (IDLE/CONV/SEND).
- Sub-module `fp16_pack`: combinational acc+exp → FP16 converter (LOD, shift, round, saturate/flush); instantiated once, muxed by idx.

## Test plan
- N=2, exp=15 all PEs, acc = FFFFC800, FFFFAC00, FFFFA800, FFFF9000, out_ready=1 → out_data CB00, CD40, CD80, CF00, idx 0..3, out_last on idx 3 only, busy low 8 cycles after capture.
- acc = 0 at PE 1, 32'h00000400 exp 15 at PE 0 → 0000 and 3C00.
- acc = 32'h7FFFFFFF, exp 31 → 7BFF; acc = 32'h80000000, exp 31 → FBFF; acc = 1, exp 0 → 0000.
- acc = 32'h00000FFF, exp 15: with ACC_DRAIN_RNE_EN → 4400; without → 43FF.
- out_ready low for 5 cycles on idx 1 → outputs stable, no skip/duplicate; second done rise during drain → overrun=1, stream unaffected.
- rst pulsed low mid-drain at idx 2 → out_valid 0, busy 0 next edge; new done rise restarts at idx 0.
